// File: rtl/irq_servicer.sv
// irq_servicer: services one interrupt per irq_i assertion. It reads the
// mask and flag registers of an IRQ controller over Wishbone, picks one
// pending source round-robin, hands it to a handler through a valid/ack
// handshake (with an acknowledge timeout), then clears that source's flag.
module irq_servicer #(
    parameter int          NUM_SOURCES = 4,
    parameter logic [15:0] FLAG_ADR    = 16'h0000,
    parameter logic [15:0] MASK_ADR    = 16'h0002,
    parameter int          TIMEOUT     = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        en_i,
    input  logic        irq_i,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [15:0] wbm_adr_o,
    output logic [15:0] wbm_dat_o,
    input  logic [15:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic        svc_valid_o,
    output logic [3:0]  svc_id_o,
    input  logic        svc_ack_i,
    output logic        timeout_o
);

    // Flag/mask width: hardware sources plus the user IRQ in the top bit.
    localparam int W = NUM_SOURCES + 1;

    typedef enum logic [2:0] {
        IDLE,
        RD_MASK,
        RD_FLAG,
        SELECT,
        DISPATCH,
        WR_CLR,
        GAP
    } state_t;

    state_t         state_q, state_d;
    logic           cyc_q, cyc_d;
    logic           stb_q, stb_d;
    logic           we_q, we_d;
    logic [15:0]    adr_q, adr_d;
    logic [15:0]    dat_q, dat_d;
    logic [W-1:0]   mask_q, mask_d;
    logic [W-1:0]   flag_q, flag_d;
    logic [3:0]     last_id_q, last_id_d;
    logic [3:0]     svc_id_q, svc_id_d;
    logic           svc_valid_q, svc_valid_d;
    logic           timeout_q, timeout_d;
    logic [7:0]     cnt_q, cnt_d;

    logic [W-1:0]   pending;
    logic           hi_found;
    logic [3:0]     hi_id;
    logic [3:0]     lo_id;
    logic [3:0]     winner;

    // Only the low W data bits carry flag/mask state; the rest are ignored.
    logic           unused_dat;
    assign unused_dat = ^wbm_dat_i;

    // Round-robin pick: smallest pending index above last_id, else the
    // smallest pending index at or below it (the wrap-around case).
    always_comb begin
        pending  = flag_q & mask_q;
        hi_found = 1'b0;
        hi_id    = 4'd0;
        lo_id    = 4'd0;
        // Descending scan so the last hit in each half is its lowest index.
        for (int j = W - 1; j >= 0; j--) begin
            if (pending[j]) begin
                if (j > int'(last_id_q)) begin
                    hi_found = 1'b1;
                    hi_id    = 4'(j);
                end else begin
                    lo_id    = 4'(j);
                end
            end
        end
        winner = hi_found ? hi_id : lo_id;
    end

    // Next-state and registered-output logic for the service sequence.
    always_comb begin
        // NOTE: every _d gets a default before the case so no path leaves a
        // variable unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        mask_d      = mask_q;
        flag_d      = flag_q;
        last_id_d   = last_id_q;
        svc_id_d    = svc_id_q;
        svc_valid_d = svc_valid_q;
        timeout_d   = 1'b0;
        cnt_d       = cnt_q;

        case (state_q)
            IDLE: begin
                if (irq_i && en_i) begin
                    state_d = RD_MASK;
                end
            end

            // Each bus state spends its first cycle with stb low, so back-to-
            // back transactions always see at least one idle cycle between.
            RD_MASK: begin
                if (!stb_q) begin
                    cyc_d = 1'b1;
                    stb_d = 1'b1;
                    we_d  = 1'b0;
                    adr_d = MASK_ADR;
                    dat_d = 16'h0000;
                end else if (wbm_ack_i) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    mask_d  = wbm_dat_i[W-1:0];
                    state_d = RD_FLAG;
                end
            end

            RD_FLAG: begin
                if (!stb_q) begin
                    cyc_d = 1'b1;
                    stb_d = 1'b1;
                    we_d  = 1'b0;
                    adr_d = FLAG_ADR;
                    dat_d = 16'h0000;
                end else if (wbm_ack_i) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    flag_d  = wbm_dat_i[W-1:0];
                    state_d = SELECT;
                end
            end

            SELECT: begin
                if (pending == '0) begin
                    state_d = GAP;
                end else begin
                    svc_id_d    = winner;
                    last_id_d   = winner;
                    svc_valid_d = 1'b1;
                    cnt_d       = 8'd0;
                    state_d     = DISPATCH;
                end
            end

            // Ack has priority over a timeout landing in the same cycle.
            DISPATCH: begin
                cnt_d = cnt_q + 8'd1;
                if (svc_valid_q && svc_ack_i) begin
                    svc_valid_d = 1'b0;
                    state_d     = WR_CLR;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    svc_valid_d = 1'b0;
                    timeout_d   = 1'b1;
                    state_d     = WR_CLR;
                end
            end

            // The controller ANDs written data into its flags, so a single
            // zero at the serviced index clears only that source.
            WR_CLR: begin
                if (!stb_q) begin
                    cyc_d = 1'b1;
                    stb_d = 1'b1;
                    we_d  = 1'b1;
                    adr_d = FLAG_ADR;
                    dat_d = ~(16'h0001 << svc_id_q);
                end else if (wbm_ack_i) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = GAP;
                end
            end

            GAP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset; last_id starts at the top index
    // so the first search after reset begins at source 0.
    always_ff @(posedge wb_clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (wb_rst_i) begin
            state_q     <= IDLE;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= 16'h0000;
            dat_q       <= 16'h0000;
            mask_q      <= '0;
            flag_q      <= '0;
            last_id_q   <= 4'(NUM_SOURCES);
            svc_id_q    <= 4'd0;
            svc_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            cnt_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            mask_q      <= mask_d;
            flag_q      <= flag_d;
            last_id_q   <= last_id_d;
            svc_id_q    <= svc_id_d;
            svc_valid_q <= svc_valid_d;
            timeout_q   <= timeout_d;
            cnt_q       <= cnt_d;
        end
    end

    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = stb_q;
    assign wbm_we_o    = we_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;
    assign svc_valid_o = svc_valid_q;
    assign svc_id_o    = svc_id_q;
    assign timeout_o   = timeout_q;

endmodule

// File: doc/irq_servicer.md
IRQ_SERVICER -- requirements
Module: irq_servicer

Interface
REQ-001 The block SHALL have parameter NUM_SOURCES, default 4, meaning the number of hardware IRQ sources (flag/mask width is NUM_SOURCES+1, the top bit being the user IRQ).
REQ-002 The block SHALL have parameter FLAG_ADR, default 16'h0000, meaning the Wishbone address of the IRQ flag register.
REQ-003 The block SHALL have parameter MASK_ADR, default 16'h0002, meaning the Wishbone address of the IRQ mask register.
REQ-004 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum handler-acknowledge wait in cycles (8-bit counter).
REQ-005 The block SHALL have port wb_clk_i, input, 1, the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port wb_rst_i, input, 1, reset, synchronous and active-high.
REQ-007 The block SHALL have port en_i, input, 1, servicing enable.
REQ-008 The block SHALL have port irq_i, input, 1, the interrupt from the IRQ controller.
REQ-009 The block SHALL have Wishbone master ports wbm_cyc_o (output, 1), wbm_stb_o (output, 1), wbm_we_o (output, 1), wbm_adr_o (output, 16), wbm_dat_o (output, 16), wbm_dat_i (input, 16) and wbm_ack_i (input, 1).
REQ-010 The block SHALL have port svc_valid_o, output, 1, handler service request.
REQ-011 The block SHALL have port svc_id_o, output, 4, the index of the source being serviced.
REQ-012 The block SHALL have port svc_ack_i, input, 1, handler done.
REQ-013 The block SHALL have port timeout_o, output, 1, a one-cycle pulse when the handler ack times out.

Function
REQ-014 The FSM SHALL have states IDLE, RD_MASK, RD_FLAG, SELECT, DISPATCH, WR_CLR and GAP.
REQ-015 IDLE SHALL go to RD_MASK when irq_i=1 and en_i=1; otherwise it stays in IDLE.
REQ-016 Each bus state SHALL assert cyc/stb with adr/we/dat held constant until wbm_ack_i is sampled high, and SHALL deassert cyc/stb on the following cycle.
REQ-017 stb SHALL never be high on two consecutive transactions without at least one low cycle between them.
REQ-018 RD_MASK SHALL read MASK_ADR (we=0), capture wbm_dat_i[NUM_SOURCES:0] into mask_q, then go to RD_FLAG.
REQ-019 RD_FLAG SHALL read FLAG_ADR (we=0), capture flag_q, then go to SELECT.
REQ-020 SELECT SHALL compute pending = flag_q & mask_q in one cycle.
REQ-021 If pending=0 (spurious), SELECT SHALL go to GAP with no dispatch.
REQ-022 Otherwise SELECT SHALL choose the winner round-robin: the first set bit searching upward from last_id+1, wrapping from NUM_SOURCES to 0.
REQ-023 SELECT SHALL register the winner into svc_id_o and last_id, then go to DISPATCH.
REQ-024 DISPATCH SHALL hold svc_valid_o=1 from its first cycle and SHALL clear svc_valid_o the cycle after svc_ack_i is sampled high, then go to WR_CLR.
REQ-025 svc_ack_i SHALL be ignored while svc_valid_o=0.
REQ-026 The timeout counter SHALL clear on DISPATCH entry and increment each DISPATCH cycle.
REQ-027 If the counter reaches TIMEOUT with no ack, timeout_o SHALL pulse for 1 cycle, svc_valid_o SHALL drop and the FSM SHALL go to WR_CLR.
REQ-028 If the ack and the timeout occur in the same cycle, the ack SHALL win and timeout_o SHALL not pulse.
REQ-029 WR_CLR SHALL write FLAG_ADR (we=1) with dat = all ones except bit svc_id_o = 0 (the write ANDs, so only the serviced flag clears), then go to GAP.
REQ-030 GAP SHALL last exactly 1 cycle, then go to IDLE, re-evaluating irq_i.
REQ-031 en_i deasserted mid-sequence SHALL NOT abort the sequence: it completes through GAP, and only IDLE honours en_i.
REQ-032 Latency from irq_i rising in IDLE to svc_valid_o=1, with a zero-wait slave (ack on the cycle after stb), SHALL be 8 cycles.

Reset
REQ-033 wb_rst_i=1 SHALL force IDLE, drop all outputs to 0 (cyc, stb, we, adr, dat, svc_valid_o, svc_id_o, timeout_o), clear mask_q, flag_q and the counter, and set last_id=NUM_SOURCES so the first search starts at 0.
REQ-034 Reset asserted mid-bus-cycle SHALL drop cyc/stb on the next edge, with no further transaction until reset is released.

Verification
REQ-035 The bench SHALL cover: mask=5'h1F, flag=5'b00100, irq_i=1 -> svc_id_o=2, then write to FLAG_ADR with dat=16'hFFFB.
REQ-036 The bench SHALL cover: flag=5'b00101 held pending and re-raised after each clear -> service order 0, 2, 0, 2 (round-robin).
REQ-037 The bench SHALL cover: flag=5'b10000 (user IRQ), mask=5'h1F -> svc_id_o=4, clear dat=16'hFFEF.
REQ-038 The bench SHALL cover: svc_ack_i never asserted -> timeout_o pulses exactly once, TIMEOUT cycles after svc_valid_o rises, and the flag clear still occurs.
REQ-039 The bench SHALL cover: flag=5'b00010, mask=5'b11101 -> no svc_valid_o and no write, FSM returns to IDLE.
REQ-040 The bench SHALL cover: wb_rst_i pulsed during RD_FLAG with stb high -> stb=0 on the next edge, all outputs 0, and the next service starts its search at index 0.
